// File: rtl/dma_uart_reader_pkg.sv
// Shared definitions for the DMA/UART host bridge: FSM states, command byte
// layout and fp16 / cherry-float width constants.
package dma_uart_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD_EN,
        CMD_GAP,
        CMD_WAIT,
        RECV_MSB,
        RECV_LSB,
        DONE,
        TIMEOUT
    } dma_state_t;

    // Command byte: bit 7 selects read (0) or write (1), bits 6:0 carry the address.
    localparam int unsigned CMD_RW_BIT = 7;
    localparam int unsigned CMD_ADDR_W = 7;
    localparam logic        CMD_READ   = 1'b0;

    // fp16 travels over the wire; the host side works in 18-bit cherry floats.
    localparam int unsigned FP16_W     = 16;
    localparam int unsigned CHERRY_W   = 18;
    localparam int unsigned CHERRY_PAD = CHERRY_W - FP16_W;

    function automatic logic [7:0] make_read_cmd(input logic [CMD_ADDR_W-1:0] addr);
        logic [7:0] cmd;
        cmd                   = '0;
        cmd[CMD_ADDR_W-1:0]   = addr;
        cmd[CMD_RW_BIT]       = CMD_READ;
        return cmd;
    endfunction

    // The two mantissa bits that fp16 lacks are zero-filled.
    function automatic logic [CHERRY_W-1:0] fp16_to_cherry(input logic [FP16_W-1:0] f);
        return {f, {CHERRY_PAD{1'b0}}};
    endfunction

endpackage

// File: rtl/dma_uart_reader_uart.sv
// 8N1 UART transmitter and receiver used by the DMA bridge blocks.
module uart_tx #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned BIT_RATE = 9600
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data,
    output logic       uart_tx_busy,
    output logic       uart_txd
);
    localparam int unsigned CPB = CLK_HZ / BIT_RATE;

    logic [31:0] cyc;
    logic [3:0]  bit_idx;
    logic [8:0]  shreg;

    // Shift out start bit, 8 data bits LSB first, then stop bit; busy covers the whole frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_tx_busy <= 1'b0;
            uart_txd     <= 1'b1;
            cyc          <= '0;
            bit_idx      <= '0;
            shreg        <= '1;
        end else if (!uart_tx_busy) begin
            if (uart_tx_en) begin
                uart_tx_busy <= 1'b1;
                uart_txd     <= 1'b0;
                shreg        <= {1'b1, uart_tx_data};
                cyc          <= '0;
                bit_idx      <= '0;
            end
        end else if (cyc == CPB - 1) begin
            cyc <= '0;
            if (bit_idx == 4'd9) begin
                uart_tx_busy <= 1'b0;
                uart_txd     <= 1'b1;
            end else begin
                uart_txd <= shreg[0];
                shreg    <= {1'b1, shreg[8:1]};
                bit_idx  <= bit_idx + 4'd1;
            end
        end else begin
            cyc <= cyc + 32'd1;
        end
    end
endmodule

module uart_rx #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned BIT_RATE = 9600
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rxd,
    input  logic       uart_rx_en,
    output logic       uart_rx_valid,
    output logic [7:0] uart_rx_data
);
    localparam int unsigned CPB  = CLK_HZ / BIT_RATE;
    localparam int unsigned HALF = CPB / 2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   rx_state, rx_next;
    logic        rxd_m, rxd_s;
    logic [31:0] cyc;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
        end
    end

    // Frame sequencing: confirm start at mid-bit, then sample every bit period.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (uart_rx_en && !rxd_s) rx_next = RX_START;
            RX_START: if (cyc == HALF - 1) rx_next = rxd_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cyc == CPB - 1 && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (cyc == CPB - 1) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Bit timing, data shifting and the one-cycle valid strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state      <= RX_IDLE;
            cyc           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_data  <= '0;
        end else begin
            rx_state      <= rx_next;
            uart_rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    cyc     <= '0;
                    bit_idx <= '0;
                end
                RX_START: cyc <= (cyc == HALF - 1) ? '0 : cyc + 32'd1;
                RX_DATA: begin
                    if (cyc == CPB - 1) begin
                        cyc     <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cyc <= cyc + 32'd1;
                    end
                end
                RX_STOP: begin
                    if (cyc == CPB - 1) begin
                        cyc <= '0;
                        if (rxd_s) begin
                            uart_rx_valid <= 1'b1;
                            uart_rx_data  <= shreg;
                        end
                    end else begin
                        cyc <= cyc + 32'd1;
                    end
                end
                default: cyc <= '0;
            endcase
        end
    end
endmodule

// File: rtl/dma_uart_reader.sv
// Host read bridge: sends a read command over UART, collects the two-byte fp16
// reply and presents it as an 18-bit cherry float, with an inter-byte timeout.
module dma_uart_reader
    import dma_uart_reader_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned BIT_RATE       = 9600,
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  re,
    input  logic [CMD_ADDR_W-1:0] dma_dat_addr,
    output logic [CHERRY_W-1:0]   dma_dat_r,
    output logic                  dma_dat_r_valid,
    output logic                  dma_err,
    output logic                  busy,
    input  logic                  uart_rxd,
    output logic                  uart_txd
);

    dma_state_t  state, state_next;

    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;

    logic [1:0]  byte_cnt;
    logic [7:0]  msb_q, lsb_q;
    logic [31:0] tmo_cnt;
    logic        armed;
    logic        in_recv;
    logic        tmo_hit;

    uart_tx #(
        .CLK_HZ   (CLK_HZ),
        .BIT_RATE (BIT_RATE)
    ) u_uart_tx (
        .clk          (clk),
        .resetn       (resetn),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_txd     (uart_txd)
    );

    uart_rx #(
        .CLK_HZ   (CLK_HZ),
        .BIT_RATE (BIT_RATE)
    ) u_uart_rx (
        .clk           (clk),
        .resetn        (resetn),
        .uart_rxd      (uart_rxd),
        .uart_rx_en    (1'b1),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data)
    );

    assign armed   = (state == CMD_EN) || (state == CMD_GAP) || (state == CMD_WAIT) ||
                     (state == RECV_MSB) || (state == RECV_LSB);
    assign in_recv = (state == RECV_MSB) || (state == RECV_LSB);
    assign tmo_hit = (tmo_cnt == TIMEOUT_CYCLES - 1) && !uart_rx_valid;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic; reply bytes may already be buffered when RECV states are entered.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (re) state_next = CMD_EN;
            CMD_EN:   state_next = CMD_GAP;
            CMD_GAP:  state_next = CMD_WAIT;
            CMD_WAIT: if (!uart_tx_busy) state_next = RECV_MSB;
            RECV_MSB: begin
                if (byte_cnt != 2'd0) state_next = RECV_LSB;
                else if (tmo_hit)     state_next = TIMEOUT;
            end
            RECV_LSB: begin
                if (byte_cnt == 2'd2) state_next = DONE;
                else if (tmo_hit)     state_next = TIMEOUT;
            end
            DONE:     state_next = IDLE;
            TIMEOUT:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Reply byte capture, MSB first; bytes outside an active transaction are dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            byte_cnt <= '0;
            msb_q    <= '0;
            lsb_q    <= '0;
        end else if (!armed) begin
            byte_cnt <= '0;
        end else if (uart_rx_valid && byte_cnt != 2'd2) begin
            if (byte_cnt == 2'd0) msb_q <= uart_rx_data;
            else                  lsb_q <= uart_rx_data;
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Idle-time counter while waiting for reply bytes; restarts on each byte and state change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            tmo_cnt <= '0;
        else if (in_recv && state_next == state && !uart_rx_valid)
            tmo_cnt <= tmo_cnt + 32'd1;
        else
            tmo_cnt <= '0;
    end

    // Registered outputs, decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dma_dat_r       <= '0;
            dma_dat_r_valid <= 1'b0;
            dma_err         <= 1'b0;
            busy            <= 1'b0;
            uart_tx_en      <= 1'b0;
            uart_tx_data    <= '0;
        end else begin
            dma_dat_r_valid <= (state_next == DONE);
            dma_err         <= (state_next == TIMEOUT);
            busy            <= (state_next == CMD_EN)   || (state_next == CMD_GAP)  ||
                               (state_next == CMD_WAIT) || (state_next == RECV_MSB) ||
                               (state_next == RECV_LSB);
            uart_tx_en      <= (state_next == CMD_EN);
            if (state == IDLE && re)
                uart_tx_data <= make_read_cmd(dma_dat_addr);
            if (state_next == DONE)
                dma_dat_r <= fp16_to_cherry({msb_q, lsb_q});
        end
    end

endmodule

// File: doc/dma_uart_reader.md
DMA_UART_READER -- requirements
Module: dma_uart_reader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600, UART baud rate.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5000000, the maximum number of idle clk cycles allowed between response bytes.
REQ-004 SHALL have port clk, input, 1, the only clock, rising edge.
REQ-005 SHALL have port resetn, input, 1, reset; asynchronous assertion, active-low.
REQ-006 SHALL have port re, input, 1, read request; sampled only in IDLE.
REQ-007 SHALL have port dma_dat_addr, input, 7, host word address; latched when re is accepted.
REQ-008 SHALL have port dma_dat_r, output, 18, read result as a cherry float.
REQ-009 SHALL have port dma_dat_r_valid, output, 1, one-cycle pulse marking a new dma_dat_r.
REQ-010 SHALL have port dma_err, output, 1, one-cycle pulse on timeout.
REQ-011 SHALL have port busy, output, 1, high while a transaction is in flight.
REQ-012 SHALL have port uart_rxd, input, 1, UART receive pin.
REQ-013 SHALL have port uart_txd, output, 1, UART transmit pin.

Function
REQ-014 States SHALL be: IDLE, CMD_EN, CMD_GAP, CMD_WAIT, RECV_MSB, RECV_LSB, DONE, TIMEOUT.
REQ-015 In IDLE, re=1 SHALL latch dma_dat_addr, move to CMD_EN, and set busy=1 on the next edge.
REQ-016 In CMD_EN, uart_tx_en SHALL be 1 for exactly one cycle with uart_tx_data={1'b0, addr}; bit7=0 encodes a read command.
REQ-017 CMD_GAP SHALL last one cycle with uart_tx_en=0; CMD_WAIT SHALL then hold until uart_tx_busy=0, then go to RECV_MSB.
REQ-018 RX capture SHALL be armed on entry to CMD_EN; any uart_rx_valid byte seen in IDLE SHALL be discarded.
REQ-019 Bytes received during CMD_GAP or CMD_WAIT SHALL be retained and consumed in order (MSB first) and SHALL NOT be lost.
REQ-020 The first byte received SHALL be fp16[15:8]; the second SHALL be fp16[7:0].
REQ-021 Conversion: dma_dat_r SHALL equal {fp16, 2'b00}, i.e. the two dropped mantissa LSBs are zero-filled.
REQ-022 On receipt of the second byte the FSM SHALL enter DONE; in DONE, dma_dat_r SHALL be updated, dma_dat_r_valid=1 and busy=0 for one cycle, then the FSM SHALL return to IDLE.
REQ-023 dma_dat_r SHALL hold its value until the next successful read; it SHALL NOT change on error.
REQ-024 The timeout counter SHALL run in RECV_MSB and RECV_LSB, SHALL clear on every received byte and on state entry, and at TIMEOUT_CYCLES SHALL force TIMEOUT.
REQ-025 TIMEOUT SHALL pulse dma_err for one cycle, set busy=0, discard any partial byte, and return to IDLE.
REQ-026 re while busy=1 SHALL be ignored (no queueing); re=1 in the DONE or TIMEOUT cycle SHALL be ignored.
REQ-027 The minimum latency from re to dma_dat_r_valid SHALL be 3 + uart_tx busy time + two RX byte times in cycles.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 resetn=0 SHALL asynchronously force IDLE, busy=0, dma_dat_r=0, dma_dat_r_valid=0, dma_err=0, uart_tx_en=0, the byte counter to 0 and the timeout counter to 0.
REQ-030 Reset mid-transaction SHALL abandon it with no valid or err pulse; a UART frame already in progress on uart_txd MAY be truncated.

Structure
REQ-031 The state enum, the read/write command bit positions and the fp16<->cherry float width constants SHALL live in a shared dma package, also used by dma_uart.
REQ-032 The block SHALL instantiate the existing uart_tx and uart_rx (uart_rx_en tied 1, 8-bit payload, same CLK_HZ/BIT_RATE); no new sub-module is needed.

Verification
REQ-033 re with addr=7'h15; host model replies 8'h3C, 8'h00 -> TX byte 8'h15; dma_dat_r=18'h0F000; one valid pulse; busy falls the same cycle.
REQ-034 Host replies 8'hBC, 8'hFF -> dma_dat_r=18'h2F3FC.
REQ-035 Host sends only the MSB, with TIMEOUT_CYCLES=1000 -> dma_err pulses 1000 cycles after the MSB; no valid; dma_dat_r keeps its previous value.
REQ-036 Stray RX byte 8'hAA sent while IDLE, then a normal read returning 8'h40, 8'h00 -> dma_dat_r=18'h10000 (stray byte ignored).
REQ-037 re pulsed again during RECV_LSB -> only one command byte on uart_txd and only one valid pulse.
REQ-038 resetn asserted during RECV_MSB -> busy=0 immediately; a subsequent read completes correctly.
